// File: rtl/sdc_pkg.sv
// Shared definitions for the SD DAT-line block receiver: status codes,
// receiver state encoding and the CRC16 generator polynomial.
package sdc_pkg;

  localparam logic [1:0] SDC_ST_OK  = 2'd0;
  localparam logic [1:0] SDC_ST_CRC = 2'd1;
  localparam logic [1:0] SDC_ST_TO  = 2'd2;
  localparam logic [1:0] SDC_ST_OVR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_START,
    ST_DATA,
    ST_CRC,
    ST_END
  } rx_state_t;

  // x^16 + x^12 + x^5 + 1
  localparam logic [15:0] SDC_CRC16_POLY = 16'h1021;

endpackage

// File: rtl/sdc_crc16.sv
// Serial CRC16 (x^16+x^12+x^5+1, init 0): one data bit absorbed per enable.
module sdc_crc16
  import sdc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);

  logic        fb;
  logic [15:0] crc_reg;

  assign fb  = din ^ crc_reg[15];
  assign crc = crc_reg;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      crc_reg <= '0;
    end else if (en) begin
      crc_reg <= {crc_reg[14:0], 1'b0} ^ (fb ? SDC_CRC16_POLY : 16'h0000);
    end
  end

endmodule

// File: rtl/sdc_dat_rx.sv
// SD-card DAT-line block receiver: 1/4-bit bus, runtime block length,
// per-line CRC16 and end-bit checks, overrun detection and abort.
module sdc_dat_rx
  import sdc_pkg::*;
#(
  parameter  int MAX_BYTES    = 512,
  parameter  int TIMEOUT_BITS = 11,
  localparam int LEN_BITS     = $clog2(MAX_BYTES + 1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sd_clk_sample,
  input  logic [3:0]              sd_dat_in,
  input  logic                    start,
  input  logic                    wide,
  input  logic [LEN_BITS-1:0]     byte_count,
  input  logic [TIMEOUT_BITS-1:0] timeout,
  input  logic                    abort,
  input  logic                    out_full,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              status
);

  localparam logic [LEN_BITS-1:0]     MAX_LEN = LEN_BITS'(MAX_BYTES);
  localparam logic [LEN_BITS-1:0]     LEN_ONE = LEN_BITS'(1);
  localparam logic [TIMEOUT_BITS-1:0] TO_ONE  = TIMEOUT_BITS'(1);

  rx_state_t                 state_reg, state_next;
  logic                      wide_reg, wide_next;
  logic [LEN_BITS-1:0]       len_reg, len_next;
  logic [TIMEOUT_BITS-1:0]   to_reg, to_next;
  logic [LEN_BITS-1:0]       byte_reg, byte_next;
  logic [2:0]                bit_reg, bit_next;
  logic [3:0]                crc_cnt_reg, crc_cnt_next;
  logic [7:0]                sh_reg, sh_next;
  logic                      crc_err_reg, crc_err_next;
  logic                      ovr_reg, ovr_next;
  logic [7:0]                out_data_reg, out_data_next;
  logic                      out_valid_reg, out_valid_next;
  logic                      done_reg, done_next;
  logic [1:0]                status_reg, status_next;

  logic                      crc_clr;
  logic                      crc_en;
  logic [15:0]               crc_val [4];
  logic [3:0]                crc_mismatch;
  logic [3:0]                active;
  logic                      start_bit;
  logic                      end_bad;
  logic [7:0]                sample_byte;
  logic [2:0]                last_bit;

  assign active      = wide_reg ? 4'hF : 4'h1;
  assign start_bit   = wide_reg ? (sd_dat_in == 4'b0000) : !sd_dat_in[0];
  assign end_bad     = |(~sd_dat_in & active);
  assign sample_byte = wide_reg ? {sh_reg[3:0], sd_dat_in} : {sh_reg[6:0], sd_dat_in[0]};
  assign last_bit    = wide_reg ? 3'd1 : 3'd7;

  // Inactive lines still run their CRC in 1-bit mode; their result is masked.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_line
      sdc_crc16 u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (crc_clr),
        .en    (crc_en),
        .din   (sd_dat_in[gi]),
        .crc   (crc_val[gi])
      );
      assign crc_mismatch[gi] = sd_dat_in[gi] ^ crc_val[gi][~crc_cnt_reg];
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    wide_next      = wide_reg;
    len_next       = len_reg;
    to_next        = to_reg;
    byte_next      = byte_reg;
    bit_next       = bit_reg;
    crc_cnt_next   = crc_cnt_reg;
    sh_next        = sh_reg;
    crc_err_next   = crc_err_reg;
    ovr_next       = ovr_reg | (out_valid_reg & out_full);
    out_data_next  = out_data_reg;
    out_valid_next = 1'b0;
    done_next      = 1'b0;
    status_next    = status_reg;
    crc_clr        = 1'b0;
    crc_en         = 1'b0;

    if (abort) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_next   = ST_WAIT_START;
            wide_next    = wide;
            len_next     = (byte_count == '0 || byte_count > MAX_LEN) ? MAX_LEN : byte_count;
            to_next      = timeout;
            crc_clr      = 1'b1;
            crc_err_next = 1'b0;
            ovr_next     = 1'b0;
          end
        end

        ST_WAIT_START: begin
          if (sd_clk_sample) begin
            if (start_bit) begin
              state_next = ST_DATA;
              byte_next  = '0;
              bit_next   = '0;
            end else if (to_reg == '0) begin
              state_next  = ST_IDLE;
              done_next   = 1'b1;
              status_next = SDC_ST_TO;
            end else begin
              to_next = to_reg - TO_ONE;
            end
          end
        end

        ST_DATA: begin
          if (sd_clk_sample) begin
            crc_en  = 1'b1;
            sh_next = sample_byte;
            if (bit_reg == last_bit) begin
              bit_next       = '0;
              out_data_next  = sample_byte;
              out_valid_next = 1'b1;
              if (byte_reg == len_reg - LEN_ONE) begin
                state_next   = ST_CRC;
                crc_cnt_next = '0;
              end else begin
                byte_next = byte_reg + LEN_ONE;
              end
            end else begin
              bit_next = bit_reg + 3'd1;
            end
          end
        end

        ST_CRC: begin
          if (sd_clk_sample) begin
            crc_err_next = crc_err_reg | (|(crc_mismatch & active));
            if (crc_cnt_reg == 4'd15) begin
              state_next = ST_END;
            end else begin
              crc_cnt_next = crc_cnt_reg + 4'd1;
            end
          end
        end

        ST_END: begin
          if (sd_clk_sample) begin
            state_next = ST_IDLE;
            done_next  = 1'b1;
            if (ovr_next) begin
              status_next = SDC_ST_OVR;
            end else if (crc_err_reg || end_bad) begin
              status_next = SDC_ST_CRC;
            end else begin
              status_next = SDC_ST_OK;
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      wide_reg      <= 1'b0;
      len_reg       <= '0;
      to_reg        <= '0;
      byte_reg      <= '0;
      bit_reg       <= '0;
      crc_cnt_reg   <= '0;
      sh_reg        <= '0;
      crc_err_reg   <= 1'b0;
      ovr_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      status_reg    <= '0;
    end else begin
      state_reg     <= state_next;
      wide_reg      <= wide_next;
      len_reg       <= len_next;
      to_reg        <= to_next;
      byte_reg      <= byte_next;
      bit_reg       <= bit_next;
      crc_cnt_reg   <= crc_cnt_next;
      sh_reg        <= sh_next;
      crc_err_reg   <= crc_err_next;
      ovr_reg       <= ovr_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      done_reg      <= done_next;
      status_reg    <= status_next;
    end
  end

  assign out_data  = out_data_reg;
  assign out_valid = out_valid_reg;
  assign busy      = (state_reg != ST_IDLE);
  assign done      = done_reg;
  assign status    = status_reg;

endmodule

// File: tb/tb_sdc_dat_rx.sv
// Self-checking bench for sdc_dat_rx: random block streams built from the
// SD framing rules and compared against the receiver's byte/status output.
module tb_sdc_dat_rx;

  localparam int LEN_BITS = 10;
  localparam int TO_BITS  = 11;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               sd_clk_sample = 1'b0;
  logic [3:0]         sd_dat_in = 4'hF;
  logic               start = 1'b0;
  logic               wide = 1'b0;
  logic [LEN_BITS-1:0] byte_count = '0;
  logic [TO_BITS-1:0] timeout = '0;
  logic               abort = 1'b0;
  logic               out_full = 1'b0;
  logic [7:0]         out_data;
  logic               out_valid;
  logic               busy;
  logic               done;
  logic [1:0]         status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  sdc_dat_rx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sd_clk_sample (sd_clk_sample),
    .sd_dat_in     (sd_dat_in),
    .start         (start),
    .wide          (wide),
    .byte_count    (byte_count),
    .timeout       (timeout),
    .abort         (abort),
    .out_full      (out_full),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .busy          (busy),
    .done          (done),
    .status        (status)
  );

  // Output monitor
  logic [7:0] got[$];
  int         done_cnt = 0;
  logic [1:0] done_status = 2'b00;
  int         done_sample = 0;
  int         sample_cnt = 0;
  int         full_hits = 0;
  logic       busy_after = 1'b1;
  logic       done_prev = 1'b0;

  always @(negedge clk) begin
    if (out_valid) begin
      got.push_back(out_data);
      if (out_full) full_hits++;
    end
    if (done_prev) busy_after = busy;
    done_prev = done;
    if (done) begin
      done_cnt++;
      done_status = status;
      done_sample = sample_cnt;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] dat;
    logic       full;
  } smp_t;

  smp_t       stream[$];
  logic [7:0] tx_data[$];

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [3:0] noise3(input logic b0);
    logic [2:0] r;
    r = 3'($urandom);
    return {r, b0};
  endfunction

  task automatic push_s(input logic [3:0] d, input logic f);
    smp_t s;
    s.dat  = d;
    s.full = f;
    stream.push_back(s);
  endtask

  // Builds the DAT sample sequence for tx_data: idle lead, start bit,
  // payload, per-line CRC16 (optionally corrupted) and end bit.
  task automatic build(input bit w, input int lead, input int flip_line, input int flip_bit,
                       input int bad_end_line, input int full_byte);
    logic [15:0] crc [4];
    logic [3:0]  d;
    logic [7:0]  b;
    stream.delete();
    for (int l = 0; l < 4; l++) crc[l] = '0;
    for (int i = 0; i < lead; i++) begin
      if (w) d = 4'($urandom_range(15, 1));
      else   d = noise3(1'b1);
      push_s(d, 1'b0);
    end
    push_s(w ? 4'h0 : noise3(1'b0), 1'b0);
    for (int n = 0; n < tx_data.size(); n++) begin
      b = tx_data[n];
      if (w) begin
        for (int h = 1; h >= 0; h--) begin
          d = (h == 1) ? b[7:4] : b[3:0];
          for (int l = 0; l < 4; l++) crc[l] = crc_step(crc[l], d[l]);
          push_s(d, (n == full_byte) && (h == 0));
        end
      end else begin
        for (int k = 7; k >= 0; k--) begin
          crc[0] = crc_step(crc[0], b[k]);
          push_s(noise3(b[k]), (n == full_byte) && (k == 0));
        end
      end
    end
    for (int k = 15; k >= 0; k--) begin
      for (int l = 0; l < 4; l++) d[l] = crc[l][k] ^ ((l == flip_line) && (k == flip_bit));
      if (!w) d = noise3(d[0]);
      push_s(d, 1'b0);
    end
    d = w ? 4'hF : noise3(1'b1);
    if (bad_end_line >= 0) d[bad_end_line] = 1'b0;
    push_s(d, 1'b0);
  endtask

  task automatic send_sample(input logic [3:0] d, input logic f);
    @(posedge clk); #1;
    sd_dat_in     = d;
    out_full      = f;
    sd_clk_sample = 1'b1;
    sample_cnt++;
    @(posedge clk); #1;
    sd_clk_sample = 1'b0;
    repeat ($urandom_range(1, 0)) @(posedge clk);
  endtask

  task automatic do_start(input bit w, input int len, input int to);
    @(posedge clk); #1;
    start      = 1'b1;
    wide       = w;
    byte_count = LEN_BITS'(len);
    timeout    = TO_BITS'(to);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic clear_mon;
    got.delete();
    done_cnt   = 0;
    full_hits  = 0;
    busy_after = 1'b1;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 100 && done_cnt == 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
  endtask

  task automatic run_block(input string name, input bit w, input int len_field, input bit incr,
                           input int flip_line, input int flip_bit, input int bad_end_line,
                           input int full_byte, input bit mid_start);
    int         nbytes;
    int         bad;
    int         first_bad;
    logic [1:0] exp_st;
    nbytes = (len_field == 0 || len_field > 512) ? 512 : len_field;
    tx_data.delete();
    for (int i = 0; i < nbytes; i++) tx_data.push_back(incr ? 8'(i) : 8'($urandom));
    build(w, $urandom_range(3, 0), flip_line, flip_bit, bad_end_line, full_byte);
    if (full_byte >= 0) exp_st = 2'd3;
    else if (flip_line >= 0 || bad_end_line >= 0) exp_st = 2'd1;
    else exp_st = 2'd0;
    clear_mon();
    do_start(w, len_field, 200);
    for (int i = 0; i < stream.size(); i++) begin
      send_sample(stream[i].dat, stream[i].full);
      if (mid_start && i == 3) do_start(~w, 1, 0);
    end
    out_full = 1'b0;
    wait_done();
    checks++;
    if (got.size() !== nbytes) begin
      errors++;
      $display("FAIL %s byte_count: got %0d bytes, expected %0d", name, got.size(), nbytes);
    end
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < nbytes && i < got.size(); i++) begin
      if (got[i] !== tx_data[i]) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s data: %0d wrong bytes, first at %0d got %02h expected %02h",
               name, bad, first_bad, got[first_bad], tx_data[first_bad]);
    end
    checks++;
    if (done_cnt !== 1) begin
      errors++;
      $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt);
    end
    checks++;
    if (done_status !== exp_st) begin
      errors++;
      $display("FAIL %s status: got %0d expected %0d", name, done_status, exp_st);
    end
    checks++;
    if (busy_after !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_after_done: got %b expected 0", name, busy_after);
    end
    $display("block %s wide=%0d len=%0d bytes=%0d status=%0d", name, w, nbytes, got.size(), done_status);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, busy, done, status, out_data} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b busy=%b done=%b status=%0d data=%02h expected all 0",
               out_valid, busy, done, status, out_data);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_busy: got %b expected 0", busy);
    end
    $display("reset checked");
  endtask

  task automatic test_wide_basic;
    tx_data.delete();
    run_block("wide8_incr", 1'b1, 8, 1'b1, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_narrow_max;
    run_block("narrow_len0", 1'b0, 0, 1'b1, -1, 0, -1, -1, 1'b0);
    run_block("wide_len700", 1'b1, 700, 1'b0, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_crc_error;
    run_block("crc_flip_dat2", 1'b1, 4, 1'b0, 2, $urandom_range(15, 0), -1, -1, 1'b0);
    run_block("end_bad_dat3", 1'b1, 4, 1'b0, -1, 0, 3, -1, 1'b0);
    run_block("crc_flip_narrow", 1'b0, 3, 1'b0, 0, $urandom_range(15, 0), -1, -1, 1'b0);
  endtask

  task automatic test_timeout;
    for (int m = 0; m < 2; m++) begin
      int base;
      clear_mon();
      do_start(m == 1, 8, 5);
      base = sample_cnt;
      for (int i = 0; i < 10 && done_cnt == 0; i++) send_sample((m == 1) ? 4'b1110 : 4'hF, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if (done_cnt !== 1) begin
        errors++;
        $display("FAIL timeout%0d done_pulses: got %0d expected 1", m, done_cnt);
      end
      checks++;
      if (done_sample - base !== 6) begin
        errors++;
        $display("FAIL timeout%0d sample: done after %0d samples expected 6", m, done_sample - base);
      end
      checks++;
      if (done_status !== 2'd2) begin
        errors++;
        $display("FAIL timeout%0d status: got %0d expected 2", m, done_status);
      end
      checks++;
      if (got.size() !== 0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL timeout%0d quiet: got %0d bytes busy=%b expected 0 bytes busy=0", m, got.size(), busy);
      end
      $display("timeout mode=%0d done_at=%0d status=%0d", m, done_sample - base, done_status);
    end
  endtask

  task automatic test_overrun;
    run_block("overrun_byte3", 1'b1, 8, 1'b0, -1, 0, -1, 2, 1'b0);
    checks++;
    if (full_hits !== 1) begin
      errors++;
      $display("FAIL overrun_strobe_while_full: got %0d expected 1", full_hits);
    end
  endtask

  task automatic test_abort;
    clear_mon();
    tx_data.delete();
    for (int i = 0; i < 8; i++) tx_data.push_back(8'($urandom));
    build(1'b1, 0, -1, 0, -1, -1);
    do_start(1'b1, 8, 50);
    for (int i = 0; i < 5; i++) send_sample(stream[i].dat, 1'b0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++;
    if (got.size() !== 2) begin
      errors++;
      $display("FAIL abort_bytes: got %0d expected 2", got.size());
    end else begin
      checks++;
      if (got[0] !== tx_data[0] || got[1] !== tx_data[1]) begin
        errors++;
        $display("FAIL abort_data: got %02h %02h expected %02h %02h", got[0], got[1], tx_data[0], tx_data[1]);
      end
    end
    checks++;
    if (done_cnt !== 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: done_pulses=%0d busy=%b expected 0 and 0", done_cnt, busy);
    end
    @(posedge clk); #1;
    start = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_with_abort busy: got %b expected 0", busy);
    end
    $display("abort checked bytes=%0d", got.size());
    run_block("after_abort", 1'b1, 8, 1'b0, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_reset_mid;
    clear_mon();
    tx_data.delete();
    for (int i = 0; i < 8; i++) tx_data.push_back(8'($urandom));
    build(1'b1, 0, -1, 0, -1, -1);
    do_start(1'b1, 8, 50);
    for (int i = 0; i < 7; i++) send_sample(stream[i].dat, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || status !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid outputs: busy=%b valid=%b status=%0d expected 0 0 0", busy, out_valid, status);
    end
    repeat (4) @(posedge clk);
    checks++;
    if (done_cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid done_pulses: got %0d expected 0", done_cnt);
    end
    $display("reset mid-data checked");
    run_block("after_reset", 1'b1, 8, 1'b0, -1, 0, -1, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 8; n++) begin
      bit w;
      int len;
      int mode;
      int fl;
      int eb;
      int fb;
      w    = 1'($urandom);
      len  = $urandom_range(20, 1);
      mode = $urandom_range(3, 0);
      fl   = -1;
      eb   = -1;
      fb   = -1;
      if (mode == 1) fl = w ? $urandom_range(3, 0) : 0;
      if (mode == 2) eb = w ? $urandom_range(3, 0) : 0;
      if (mode == 3) fb = $urandom_range(len - 1, 0);
      run_block($sformatf("rand%0d_m%0d", n, mode), w, len, 1'b0, fl, $urandom_range(15, 0), eb, fb,
                1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_wide_basic();
    test_narrow_max();
    test_crc_error();
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
